// File: rtl/sockit_ghrd_st_to_onchip_writer.sv
// Avalon-ST to on-chip RAM writer.
// Captures one streaming frame into consecutive words of a 64-bit on-chip RAM,
// starting at a programmed base. The capture region can be linear (stop and
// discard the rest of the frame when full) or circular (wrap to the base).
// Every RAM-side signal is registered, so a beat accepted in cycle N is
// written in cycle N+1.
module sockit_ghrd_st_to_onchip_writer #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 64,
  parameter int BE_W    = 8,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W:0]    cfg_words,
  input  logic               cfg_wrap,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  snk_data,
  input  logic               snk_valid,
  output logic               snk_ready,
  input  logic               snk_sop,
  input  logic               snk_eop,
  input  logic [EMPTY_W-1:0] snk_empty,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frame_len,
  output logic               wrapped,
  output logic               overflow,
  output logic               err_sop
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

  // A region size of zero means the whole RAM.
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                wrap_q, wrap_d;
  logic [ADDR_W:0]     off_q, off_d;
  logic [CNT_W-1:0]    frame_len_q, frame_len_d;
  logic                wrapped_q, wrapped_d;
  logic                overflow_q, overflow_d;
  logic                err_sop_q, err_sop_d;
  logic                done_q, done_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;

  logic                acc;
  logic [ADDR_W:0]     eff_off;
  logic [ADDR_W:0]     nxt_off;
  logic [BE_W-1:0]     be_eop;

  // Next-state, datapath and status update for the capture FSM.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    words_d       = words_q;
    wrap_d        = wrap_q;
    off_d         = off_q;
    frame_len_d   = frame_len_q;
    wrapped_d     = wrapped_q;
    overflow_d    = overflow_q;
    err_sop_d     = err_sop_q;
    done_d        = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_be_d      = mem_be_q;
    mem_data_d    = mem_data_q;

    acc     = snk_valid && (state_q != IDLE);
    // A sop beat always restarts the frame at offset 0.
    eff_off = snk_sop ? '0 : off_q;
    nxt_off = eff_off + ONE_W;
    be_eop  = {BE_W{1'b1}} >> snk_empty;

    if (abort) begin
      // Drop whatever beat arrives this cycle; status bits are kept.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_d      = cfg_base;
            words_d     = (cfg_words == '0) ? DEPTH_W : cfg_words;
            wrap_d      = cfg_wrap;
            off_d       = '0;
            frame_len_d = '0;
            wrapped_d   = 1'b0;
            overflow_d  = 1'b0;
            err_sop_d   = 1'b0;
            state_d     = ARMED;
          end
        end
        ARMED, CAPTURE: begin
          // In ARMED only a sop beat opens the frame; others are discarded.
          if (acc && (snk_sop || state_q == CAPTURE)) begin
            mem_write_d   = 1'b1;
            mem_address_d = base_q + eff_off[ADDR_W-1:0];
            mem_data_d    = snk_data;
            mem_be_d      = snk_eop ? be_eop : {BE_W{1'b1}};
            if (snk_sop) begin
              frame_len_d = {{(CNT_W-1){1'b0}}, 1'b1};
              if (state_q == CAPTURE) err_sop_d = 1'b1;
            end else if (frame_len_q != {CNT_W{1'b1}}) begin
              frame_len_d = frame_len_q + 1'b1;
            end
            if (snk_eop) begin
              done_d  = 1'b1;
              off_d   = nxt_off;
              state_d = IDLE;
            end else if (nxt_off == words_q) begin
              if (wrap_q) begin
                off_d     = '0;
                wrapped_d = 1'b1;
                state_d   = CAPTURE;
              end else begin
                off_d      = nxt_off;
                overflow_d = 1'b1;
                state_d    = FLUSH;
              end
            end else begin
              off_d   = nxt_off;
              state_d = CAPTURE;
            end
          end
        end
        FLUSH: begin
          // Drain the rest of the frame without writing it.
          if (acc && snk_eop) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      words_q       <= '0;
      wrap_q        <= 1'b0;
      off_q         <= '0;
      frame_len_q   <= '0;
      wrapped_q     <= 1'b0;
      overflow_q    <= 1'b0;
      err_sop_q     <= 1'b0;
      done_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      words_q       <= words_d;
      wrap_q        <= wrap_d;
      off_q         <= off_d;
      frame_len_q   <= frame_len_d;
      wrapped_q     <= wrapped_d;
      overflow_q    <= overflow_d;
      err_sop_q     <= err_sop_d;
      done_q        <= done_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_be_q      <= mem_be_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign snk_ready      = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign frame_len      = frame_len_q;
  assign wrapped        = wrapped_q;
  assign overflow       = overflow_q;
  assign err_sop        = err_sop_q;
  assign mem_write      = mem_write_q;
  assign mem_chipselect = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_byteenable = mem_be_q;
  assign mem_writedata  = mem_data_q;

endmodule

// File: tb/tb_sockit_ghrd_st_to_onchip_writer.sv
// Bench for sockit_ghrd_st_to_onchip_writer: expected RAM writes are queued
// as beats are driven and popped when the DUT writes.
module tb_sockit_ghrd_st_to_onchip_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] cfg_base;
  logic [13:0] cfg_words;
  logic        cfg_wrap, start, abort;
  logic [63:0] snk_data;
  logic        snk_valid, snk_ready, snk_sop, snk_eop;
  logic [2:0]  snk_empty;
  logic [12:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [63:0] mem_writedata;
  logic        busy, done;
  logic [15:0] frame_len;
  logic        wrapped, overflow, err_sop;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  sockit_ghrd_st_to_onchip_writer dut (
    .clk(clk), .reset(reset), .cfg_base(cfg_base), .cfg_words(cfg_words),
    .cfg_wrap(cfg_wrap), .start(start), .abort(abort), .snk_data(snk_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_sop(snk_sop),
    .snk_eop(snk_eop), .snk_empty(snk_empty), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .busy(busy),
    .done(done), .frame_len(frame_len), .wrapped(wrapped),
    .overflow(overflow), .err_sop(err_sop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every RAM write must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (mem_write) begin
      wr_t e;
      chk("cs_eq_wr", {63'd0, mem_chipselect}, 64'd1);
      if (sb.size() == 0) begin
        chk("unexpected_write", {51'd0, mem_address}, 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {51'd0, mem_address}, {51'd0, e.addr});
        chk("wr_be", {56'd0, mem_byteenable}, {56'd0, e.be});
        chk("wr_data", mem_writedata, e.data);
      end
    end
  end

  task automatic arm(input logic [12:0] b, input logic [13:0] w, input logic wr);
    @(negedge clk);
    cfg_base = b; cfg_words = w; cfg_wrap = wr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_armed", {63'd0, busy}, 64'd1);
    chk("ready_armed", {63'd0, snk_ready}, 64'd1);
  endtask

  // Drive one beat; if a write is expected, queue it; then check the done pulse.
  task automatic beat(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] emp, input logic wr, input logic [12:0] addr,
                      input logic exp_done);
    wr_t e;
    @(negedge clk);
    snk_data = d; snk_sop = sop; snk_eop = eop; snk_empty = emp; snk_valid = 1'b1;
    if (wr) begin
      e.addr = addr;
      e.be   = eop ? (8'hFF >> emp) : 8'hFF;
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    chk("done", {63'd0, done}, {63'd0, exp_done});
    if (exp_done) chk("busy_after_eop", {63'd0, busy}, 64'd0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_empty = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cfg_base = '0; cfg_words = '0; cfg_wrap = 1'b0;
    start = 1'b0; abort = 1'b0; snk_data = '0; snk_valid = 1'b0;
    snk_sop = 1'b0; snk_eop = 1'b0; snk_empty = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, snk_ready}, 64'd0);
    chk("rst_write", {63'd0, mem_write}, 64'd0);
    chk("rst_flags", {60'd0, done, wrapped, overflow, err_sop}, 64'd0);
    chk("rst_flen", {48'd0, frame_len}, 64'd0);
    chk("rst_addr", {51'd0, mem_address}, 64'd0);
    reset = 1'b0;
    idle(1);

    // Linear 4-beat frame.
    arm(13'h100, 14'd8, 1'b0);
    beat(64'hA0, 1, 0, 0, 1, 13'h100, 0);
    beat(64'hA1, 0, 0, 0, 1, 13'h101, 0);
    beat(64'hA2, 0, 0, 0, 1, 13'h102, 0);
    beat(64'hA3, 0, 1, 0, 1, 13'h103, 1);
    idle(2);
    chk("flen4", {48'd0, frame_len}, 64'd4);

    // Partial last beats.
    arm(13'h200, 14'd8, 1'b0);
    beat(64'hB0, 1, 0, 0, 1, 13'h200, 0);
    beat(64'hB1, 0, 1, 3, 1, 13'h201, 1);
    chk("be_empty3", {56'd0, mem_byteenable}, 64'h1F);
    idle(1);
    arm(13'h300, 14'd8, 1'b0);
    beat(64'hC0, 1, 1, 7, 1, 13'h300, 1);
    chk("be_empty7", {56'd0, mem_byteenable}, 64'h01);
    chk("flen1", {48'd0, frame_len}, 64'd1);
    idle(1);

    // Circular region across the top of RAM.
    arm(13'h1FFE, 14'd4, 1'b1);
    beat(64'hD0, 1, 0, 0, 1, 13'h1FFE, 0);
    beat(64'hD1, 0, 0, 0, 1, 13'h1FFF, 0);
    beat(64'hD2, 0, 0, 0, 1, 13'h0000, 0);
    beat(64'hD3, 0, 0, 0, 1, 13'h0001, 0);
    beat(64'hD4, 0, 0, 0, 1, 13'h1FFE, 0);
    beat(64'hD5, 0, 1, 0, 1, 13'h1FFF, 1);
    idle(1);
    chk("wrapped", {63'd0, wrapped}, 64'd1);
    chk("no_ovf_wrap", {63'd0, overflow}, 64'd0);
    chk("flen6", {48'd0, frame_len}, 64'd6);

    // Linear overflow: remaining beats flushed.
    arm(13'h040, 14'd2, 1'b0);
    chk("stickies_cleared", {63'd0, wrapped}, 64'd0);
    beat(64'hE0, 1, 0, 0, 1, 13'h040, 0);
    beat(64'hE1, 0, 0, 0, 1, 13'h041, 0);
    beat(64'hE2, 0, 0, 0, 0, 13'h0, 0);
    beat(64'hE3, 0, 0, 0, 0, 13'h0, 0);
    beat(64'hE4, 0, 1, 0, 0, 13'h0, 1);
    idle(1);
    chk("overflow", {63'd0, overflow}, 64'd1);

    // ARMED discards non-sop beats; sop mid-frame restarts at base.
    arm(13'h080, 14'd8, 1'b0);
    beat(64'hF0, 0, 0, 0, 0, 13'h0, 0);
    beat(64'hF1, 0, 0, 0, 0, 13'h0, 0);
    beat(64'hF2, 1, 0, 0, 1, 13'h080, 0);
    beat(64'hF3, 0, 0, 0, 1, 13'h081, 0);
    beat(64'hF4, 1, 0, 0, 1, 13'h080, 0);
    chk("err_sop", {63'd0, err_sop}, 64'd1);
    beat(64'hF5, 0, 1, 0, 1, 13'h081, 1);
    idle(1);
    chk("flen_restart", {48'd0, frame_len}, 64'd2);

    // Abort mid-frame: beat in abort cycle dropped, no done.
    arm(13'h400, 14'd8, 1'b0);
    beat(64'h10, 1, 0, 0, 1, 13'h400, 0);
    @(negedge clk);
    snk_data = 64'h11; snk_sop = 1'b0; snk_eop = 1'b1; abort = 1'b1;
    @(posedge clk); #2;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_write", {63'd0, mem_write}, 64'd0);
    @(negedge clk); abort = 1'b0;
    idle(3);

    // Reset mid-frame.
    arm(13'h500, 14'd8, 1'b0);
    beat(64'h20, 1, 0, 0, 1, 13'h500, 0);
    @(negedge clk);
    snk_data = 64'h21; snk_sop = 1'b0; snk_eop = 1'b0; reset = 1'b1;
    #2;
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #2;
    chk("rstmid_write", {63'd0, mem_write}, 64'd0);
    chk("rstmid_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b0;
    idle(3);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
